// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
// Optional source-ID header support is enabled by defining UART_TX_ARB_SRC_ID_EN.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_ID,
    XFER,
    SEND
  } state_e;

  localparam logic [7:0] SRC_ID_MARK = 8'h80;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module uart_tx_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  logic [IW-1:0] k;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    k          = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any        = 1'b1;
        winner_idx = k;
        winner[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Define UART_TX_ARB_SRC_ID_EN to prefix each packet with a header byte 8'h80 | owner index.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 abort_o
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_e             state, state_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [IW-1:0]      gidx, gidx_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [7:0]         hold_data, hold_data_n;
  logic               hold_last, hold_last_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               abort, abort_n;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      next_ptr;

  uart_tx_arb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (req_valid_i),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  assign next_ptr = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      cnt       <= '0;
      abort     <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      gidx      <= gidx_n;
      ptr       <= ptr_n;
      hold_data <= hold_data_n;
      hold_last <= hold_last_n;
      cnt       <= cnt_n;
      abort     <= abort_n;
    end
  end

  // The stall counter only runs while waiting for the owner's next byte; SEND may stall forever.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    gidx_n      = gidx;
    ptr_n       = ptr;
    hold_data_n = hold_data;
    hold_last_n = hold_last;
    cnt_n       = cnt;
    abort_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_n = pick_onehot;
          gidx_n  = pick_idx;
          cnt_n   = '0;
`ifdef UART_TX_ARB_SRC_ID_EN
          hold_data_n = SRC_ID_MARK | 8'(pick_idx);
          hold_last_n = 1'b0;
          state_n     = SEND_ID;
`else
          state_n     = XFER;
`endif
        end
      end
      SEND_ID: begin
        if (tx_ready_i) state_n = XFER;
      end
      XFER: begin
        if (req_valid_i[gidx]) begin
          hold_data_n = req_data_i[{gidx, 3'b000} +: 8];
          hold_last_n = req_last_i[gidx];
          cnt_n       = '0;
          state_n     = SEND;
        end else if (TIMEOUT_CYC != 0) begin
          if (cnt == CNT_MAX) begin
            abort_n = 1'b1;
            grant_n = '0;
            ptr_n   = next_ptr;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          if (hold_last) begin
            ptr_n   = next_ptr;
            grant_n = '0;
            state_n = IDLE;
          end else begin
            state_n = XFER;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_valid_o  = (state == SEND) || (state == SEND_ID);
  assign tx_data_o   = tx_valid_o ? hold_data : 8'h00;
  assign req_ready_o = (state == XFER) ? grant : '0;
  assign grant_o     = grant;
  assign abort_o     = abort;

endmodule
